// File: rtl/jericalla_pkg.sv
// Shared definitions for the instruction fetch slice: word layout, halt opcode, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jericalla_pkg;

    localparam int INSTR_W = 19;
    localparam int OP_HI   = 18;
    localparam int OP_LO   = 15;
    localparam int OP_W    = OP_HI - OP_LO + 1;

    localparam logic [OP_W-1:0] HALT_OPCODE_DEF = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // Extract the opcode field from an instruction word.
    function automatic logic [OP_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[OP_HI:OP_LO];
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of program-load, control and fetched-instruction signals around instruction_fetch.
// Latency: n/a (wiring only).
// Backpressure: stall travels master->slave and freezes the fetch output.
interface instruction_fetch_if #(
    parameter int ADDR_W = 6
);
    import jericalla_pkg::*;

    logic                load_en;
    logic [ADDR_W-1:0]   load_addr;
    logic [INSTR_W-1:0]  load_data;
    logic                start;
    logic                stall;
    logic [INSTR_W-1:0]  instruction;
    logic                instr_valid;
    logic [ADDR_W-1:0]   pc;
    logic                halted;

    modport master (
        output load_en, load_addr, load_data, start, stall,
        input  instruction, instr_valid, pc, halted
    );

    modport slave (
        input  load_en, load_addr, load_data, start, stall,
        output instruction, instr_valid, pc, halted
    );

endinterface

// File: rtl/instruction_memory.sv
// DEPTH x INSTR_W instruction store: one synchronous write port, one asynchronous read port.
// Latency: write lands on the clock edge; read is combinational from rd_addr.
// Backpressure: none; caller gates wr_en.
module instruction_memory
    import jericalla_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [INSTR_W-1:0] rd_data
);

    // Contents are intentionally not reset; a program survives a controller reset.
    logic [INSTR_W-1:0] mem [DEPTH];

    // Program-load write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch controller: loads a program in IDLE, streams mem[pc] to the datapath in RUN, stops on a halt opcode.
// Latency: start in cycle N gives mem[0] on instruction with instr_valid in cycle N+2, then one word per cycle.
// Backpressure: stall=1 in RUN freezes instruction, instr_valid and pc; stall is ignored in IDLE and HALT.
module instruction_fetch
    import jericalla_pkg::*;
#(
    parameter int              DEPTH       = 64,
    parameter int              ADDR_W      = 6,
    parameter logic [OP_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.slave  fif
);

    fetch_state_t        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                vld_q, vld_d;

    logic                mem_wr_en;
    logic [INSTR_W-1:0]  mem_rd_dat;
    logic [ADDR_W-1:0]   pc_inc;

    // Loads are only accepted in IDLE and never while reset is asserted.
    assign mem_wr_en = reset && (state_q == ST_IDLE) && fif.load_en;

    instruction_memory #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_addr (fif.load_addr),
        .wr_data (fif.load_data),
        .rd_addr (pc_q),
        .rd_data (mem_rd_dat)
    );

    // Explicit wrap so a non-power-of-two DEPTH still returns to word 0.
    assign pc_inc = (pc_q == ADDR_W'(DEPTH - 1)) ? '0 : pc_q + 1'b1;

    // Next-state and output-register logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        vld_d   = vld_q;
        case (state_q)
            ST_IDLE: begin
                instr_d = '0;
                vld_d   = 1'b0;
                if (fif.start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                end
            end
            ST_RUN: begin
                if (!fif.stall) begin
                    if (opcode_of(mem_rd_dat) == HALT_OPCODE) begin
                        // Halt word is consumed here and never presented; pc stays on it.
                        state_d = ST_HALT;
                        instr_d = '0;
                        vld_d   = 1'b0;
                    end else begin
                        instr_d = mem_rd_dat;
                        vld_d   = 1'b1;
                        pc_d    = pc_inc;
                    end
                end
            end
            ST_HALT: begin
                instr_d = '0;
                vld_d   = 1'b0;
                if (fif.start) begin
                    state_d = ST_IDLE;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
                instr_d = '0;
                vld_d   = 1'b0;
            end
        endcase
    end

    // State, pc and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
        end
    end

    assign fif.instruction = instr_q;
    assign fif.instr_valid = vld_q;
    assign fif.pc          = pc_q;
    assign fif.halted      = (state_q == ST_HALT);

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: DEPTH, default 64, number of instruction memory words.
REQ-002 Parameter: ADDR_W, default 6, program counter width (log2 DEPTH).
REQ-003 Parameter: HALT_OPCODE, default 4'b1111, opcode field value that stops fetching.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-006 Port: load_en  input  1  program-load write strobe.
REQ-007 Port: load_addr  input  ADDR_W  program-load word address.
REQ-008 Port: load_data  input  19  program-load instruction word.
REQ-009 Port: start  input  1  single-cycle pulse; begins execution from address 0.
REQ-010 Port: stall  input  1  downstream not ready; hold current instruction and PC.
REQ-011 Port: instruction  output  19  registered instruction to datapath: [18:15] opcode, [14:10] write addr, [9:5] read addr 1, [4:0] read addr 2.
REQ-012 Port: instr_valid  output  1  instruction carries a real fetched word.
REQ-013 Port: pc  output  ADDR_W  address of the next word to fetch.
REQ-014 Port: halted  output  1  high while in HALT state.

Function
REQ-015 FSM states IDLE, RUN, HALT; encoding 2 bits.
REQ-016 IDLE: load_en=1 writes load_data to mem[load_addr] on that edge; load_en ignored in RUN and HALT.
REQ-017 IDLE + start=1 -> RUN next cycle, pc forced to 0; load and start in the same cycle both take effect (write lands before first fetch).
REQ-018 RUN + stall=0: instruction <= mem[pc], instr_valid <= 1, pc <= pc+1 each cycle.
REQ-019 RUN + stall=1: instruction, instr_valid and pc hold their values.
REQ-020 Latency: start in cycle N; mem[0] visible on instruction with instr_valid=1 in cycle N+2.
REQ-021 pc wrap-around: DEPTH-1 + 1 -> 0, no flag, fetch continues.
REQ-022 RUN, stall=0, mem[pc][18:15]==HALT_OPCODE: -> HALT; instruction <= 0, instr_valid <= 0, pc holds at halt word address; halt word never presented as valid.
REQ-023 HALT stall=1 and halt-word detection while stalled: no transition until stall=0.
REQ-024 HALT: instruction=0, instr_valid=0, halted=1; start=1 -> IDLE next cycle (pc <= 0); stall ignored.
REQ-025 IDLE: instruction=0, instr_valid=0, halted=0; stall and start while RUN are ignored.
REQ-026 Instruction memory: synchronous write, combinational read; contents uninitialised until loaded.

Reset
REQ-027 reset=0 at a rising edge: state IDLE, pc=0, instruction=0, instr_valid=0, halted=0, regardless of state, stall or start.
REQ-028 Reset does not clear instruction memory; reset has priority over load_en (no write during reset).

Structure
REQ-029 Shared package jericalla_pkg holds: instruction width 19, opcode field bounds [18:15], HALT_OPCODE value, FSM state constants.
REQ-030 One sub-module instruction_memory (DEPTH x 19, one write port, one async read port); FSM, pc and output register live in instruction_fetch.

Verification
REQ-031 Load mem[0..2]=19'h0_1441, 19'h1_0862, 19'h7_8000 (opcode F), start -> valid words 0x01441 then 0x10862 on cycles N+2, N+3, then halted=1, instr_valid=0, pc=2.
REQ-032 RUN with stall held 3 cycles after first valid word -> instruction and pc unchanged for 3 cycles, next word appears the cycle after stall drops.
REQ-033 Program with no halt word, DEPTH=64 -> after word 63, pc=0 and mem[0] fetched again with instr_valid=1.
REQ-034 reset=0 mid-RUN with stall=1 -> next cycle state IDLE, pc=0, instr_valid=0; memory reread after start returns previously loaded words.
REQ-035 load_en pulses in RUN to address 1 with 19'h7FFFF -> mem[1] unchanged on later fetch; same write in IDLE with start in same cycle -> new word fetched.
